// File: rtl/multicycle_main_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_main_fsm
//   Main control FSM of the multicycle RV32I core. Decodes the opcode for
//   each instruction phase and drives datapath enables, mux selects and the
//   ALUOp field that feeds the ALU decoder unmodified. Includes a
//   memory-ready wait handshake in FETCH/MEMREAD/MEMWRITE and a wrapping
//   retired-instruction counter.
//
//   Optional feature macro: ILLEGAL_TRAP_EN
//     defined   : unsupported opcodes in DECODE enter TRAP (sticky Illegal,
//                 left only through reset).
//     undefined : unsupported opcodes are dropped back to FETCH as a nop;
//                 Illegal is tied 0.
//
// Ports
//   clk        in   core clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   op[6:0]    in   instruction opcode (valid from DECODE onward)
//   MemReady   in   unified memory completes its access this cycle
//   ALUOp      out  00 add, 01 sub, 10 funct-decoded
//   ALUSrcA    out  00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    out  00 rs2, 01 ImmExt, 10 constant 4
//   ResultSrc  out  00 ALUOut, 01 Data, 10 ALUResult
//   AdrSrc     out  0 PC, 1 Result
//   IRWrite    out  load instruction register
//   PCUpdate   out  unconditional PC write
//   Branch     out  PC write if Zero
//   RegWrite   out  register file write
//   MemWrite   out  data memory write
//   Illegal    out  sticky unsupported-opcode flag
//   Instret    out  retired-instruction count (INSTRET_W bits, wraps)
//   State      out  current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_main_fsm #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic                 MemReady,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCUpdate,
    output logic                 Branch,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 Illegal,
    output logic [INSTRET_W-1:0] Instret,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t                 state_q, state_d;
    logic [1:0]             alu_op_q, alu_op_d;
    logic [1:0]             alu_src_a_q, alu_src_a_d;
    logic [1:0]             alu_src_b_q, alu_src_b_d;
    logic [1:0]             result_src_q, result_src_d;
    logic                   adr_src_q, adr_src_d;
    logic                   pc_update_q, pc_update_d;
    logic                   branch_q, branch_d;
    logic                   reg_write_q, reg_write_d;
    logic                   mem_write_q, mem_write_d;
    logic                   illegal_q, illegal_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   retire;
    logic                   fetch_ok;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Retirement happens on the edge that returns to FETCH from a final phase.
    // JAL passes through ALUWB, so it is counted there exactly once.
    always_comb begin
        retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                 ((state_q == S_MEMWRITE) && MemReady);
        instret_d = retire ? (instret_q + INSTRET_W'(1)) : instret_q;
    end

    // Outputs are decoded from the upcoming state so that the registered
    // copies line up with state_q.
    always_comb begin
        alu_op_d     = 2'b00;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        result_src_d = 2'b00;
        adr_src_d    = 1'b0;
        pc_update_d  = 1'b0;
        branch_d     = 1'b0;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        case (state_d)
            S_FETCH: begin
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
            end
            S_MEMREAD:  adr_src_d = 1'b1;
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                alu_op_d    = 2'b10;
            end
            S_ALUWB:    reg_write_d = 1'b1;
            S_BEQ: begin
                alu_src_a_d = 2'b10;
                alu_op_d    = 2'b01;
                branch_d    = 1'b1;
            end
            S_JAL: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                pc_update_d = 1'b1;
            end
            default: ;
        endcase
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q || (state_d == S_TRAP);
`else
        illegal_d = 1'b0;
`endif
    end

    // State and registered output stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            alu_op_q     <= 2'b00;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b10;
            result_src_q <= 2'b10;
            adr_src_q    <= 1'b0;
            pc_update_q  <= 1'b0;
            branch_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            illegal_q    <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            alu_op_q     <= alu_op_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            result_src_q <= result_src_d;
            adr_src_q    <= adr_src_d;
            pc_update_q  <= pc_update_d;
            branch_q     <= branch_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            illegal_q    <= illegal_d;
            instret_q    <= instret_d;
        end
    end

    // The fetch strobes follow MemReady within the cycle; reset_n is folded in
    // so they stay low while reset is held even though the state reads FETCH.
    assign fetch_ok  = reset_n && (state_q == S_FETCH) && MemReady;

    assign ALUOp     = alu_op_q;
    assign ALUSrcA   = alu_src_a_q;
    assign ALUSrcB   = alu_src_b_q;
    assign ResultSrc = result_src_q;
    assign AdrSrc    = adr_src_q;
    assign IRWrite   = fetch_ok;
    assign PCUpdate  = pc_update_q || fetch_ok;
    assign Branch    = branch_q;
    assign RegWrite  = reg_write_q;
    assign MemWrite  = mem_write_q;
    assign Illegal   = illegal_q;
    assign Instret   = instret_q;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_fsm
//   Directed bench for multicycle_main_fsm. Two instances share the stimulus:
//   the default-width one carries the functional checks, the 4-bit-counter
//   one is used for the Instret wrap case.
// ---------------------------------------------------------------------------
module tb_multicycle_main_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  op;
    logic        MemReady;

    logic [1:0]  ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic        AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, Illegal;
    logic [31:0] Instret;
    logic [3:0]  State;

    logic [1:0]  ALUOp_4, ALUSrcA_4, ALUSrcB_4, ResultSrc_4;
    logic        AdrSrc_4, IRWrite_4, PCUpdate_4, Branch_4, RegWrite_4, MemWrite_4, Illegal_4;
    logic [3:0]  Instret_4;
    logic [3:0]  State_4;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm #(.INSTRET_W(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .op(op), .MemReady(MemReady),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Illegal(Illegal),
        .Instret(Instret), .State(State)
    );

    multicycle_main_fsm #(.INSTRET_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .op(op), .MemReady(MemReady),
        .ALUOp(ALUOp_4), .ALUSrcA(ALUSrcA_4), .ALUSrcB(ALUSrcB_4), .ResultSrc(ResultSrc_4),
        .AdrSrc(AdrSrc_4), .IRWrite(IRWrite_4), .PCUpdate(PCUpdate_4), .Branch(Branch_4),
        .RegWrite(RegWrite_4), .MemWrite(MemWrite_4), .Illegal(Illegal_4),
        .Instret(Instret_4), .State(State_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held three cycles with MemReady high: fetch strobes must stay low
        reset_n  = 1'b0;
        op       = 7'b0000000;
        MemReady = 1'b1;
        repeat (3) step();
        chk("rst_state",    32'(State),     32'd0);
        chk("rst_irwrite",  32'(IRWrite),   32'd0);
        chk("rst_pcupdate", 32'(PCUpdate),  32'd0);
        chk("rst_regwrite", 32'(RegWrite),  32'd0);
        chk("rst_memwrite", 32'(MemWrite),  32'd0);
        chk("rst_branch",   32'(Branch),    32'd0);
        chk("rst_instret",  Instret,        32'd0);
        chk("rst_srcb",     32'(ALUSrcB),   32'd2);
        chk("rst_ressrc",   32'(ResultSrc), 32'd2);

        // Release; fetch stalls while MemReady is low
        reset_n  = 1'b1;
        MemReady = 1'b0;
        op       = 7'b0110011;
        step();
        chk("fetch_stall_state", 32'(State),   32'd0);
        chk("fetch_stall_ir",    32'(IRWrite), 32'd0);
        MemReady = 1'b1;
        #1;
        chk("fetch_ir",  32'(IRWrite),  32'd1);
        chk("fetch_pcu", 32'(PCUpdate), 32'd1);

        // R-type: 0,1,6,8,0
        step(); chk("r_decode", 32'(State), 32'd1);
        chk("r_dec_srca", 32'(ALUSrcA), 32'd1);
        chk("r_dec_srcb", 32'(ALUSrcB), 32'd1);
        step(); chk("r_exec", 32'(State), 32'd6);
        chk("r_exec_aluop", 32'(ALUOp), 32'd2);
        chk("r_exec_srca",  32'(ALUSrcA), 32'd2);
        chk("r_exec_srcb",  32'(ALUSrcB), 32'd0);
        step(); chk("r_aluwb", 32'(State), 32'd8);
        chk("r_aluwb_rw", 32'(RegWrite), 32'd1);
        chk("r_instret_before", Instret, 32'd0);
        step(); chk("r_fetch", 32'(State), 32'd0);
        chk("r_instret", Instret, 32'd1);

        // lw with three stalled cycles in MEMREAD: 8 cycles total
        op = 7'b0000011;
        step(); chk("lw_decode", 32'(State), 32'd1);
        step(); chk("lw_memadr", 32'(State), 32'd2);
        chk("lw_memadr_srca", 32'(ALUSrcA), 32'd2);
        step(); chk("lw_memread", 32'(State), 32'd3);
        chk("lw_adrsrc", 32'(AdrSrc), 32'd1);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("lw_hold", 32'(State), 32'd3);
        end
        MemReady = 1'b1;
        step(); chk("lw_memwb", 32'(State), 32'd4);
        chk("lw_memwb_rw",  32'(RegWrite),  32'd1);
        chk("lw_memwb_res", 32'(ResultSrc), 32'd1);
        step(); chk("lw_fetch", 32'(State), 32'd0);
        chk("lw_instret", Instret, 32'd2);

        // sw with MemReady low two cycles in MEMWRITE: MemWrite for 3 cycles
        op = 7'b0100011;
        step(); chk("sw_decode", 32'(State), 32'd1);
        step(); chk("sw_memadr", 32'(State), 32'd2);
        chk("sw_memadr_mw", 32'(MemWrite), 32'd0);
        step(); chk("sw_memwrite", 32'(State), 32'd5);
        MemReady = 1'b0;
        chk("sw_mw1", 32'(MemWrite), 32'd1);
        step(); chk("sw_mw2", 32'(MemWrite), 32'd1);
        step(); chk("sw_mw3", 32'(MemWrite), 32'd1);
        chk("sw_instret_hold", Instret, 32'd2);
        MemReady = 1'b1;
        step(); chk("sw_fetch", 32'(State), 32'd0);
        chk("sw_mw_off", 32'(MemWrite), 32'd0);
        chk("sw_instret", Instret, 32'd3);

        // beq
        op = 7'b1100011;
        step(); chk("beq_decode", 32'(State), 32'd1);
        step(); chk("beq_state", 32'(State), 32'd9);
        chk("beq_aluop",  32'(ALUOp),  32'd1);
        chk("beq_branch", 32'(Branch), 32'd1);
        step(); chk("beq_fetch", 32'(State), 32'd0);
        chk("beq_instret", Instret, 32'd4);

        // jal
        op = 7'b1101111;
        step(); chk("jal_decode", 32'(State), 32'd1);
        step(); chk("jal_state", 32'(State), 32'd10);
        chk("jal_pcu",  32'(PCUpdate), 32'd1);
        chk("jal_srcb", 32'(ALUSrcB),  32'd2);
        step(); chk("jal_aluwb", 32'(State), 32'd8);
        chk("jal_rw", 32'(RegWrite), 32'd1);
        step(); chk("jal_fetch", 32'(State), 32'd0);
        chk("jal_instret", Instret, 32'd5);

        // Unsupported opcode
        op = 7'b1111111;
        step(); chk("ill_decode", 32'(State), 32'd1);
        step();
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap",    32'(State),   32'd11);
        chk("ill_flag",    32'(Illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(); chk("ill_stay", 32'(State), 32'd11);
        end
        chk("ill_instret", Instret, 32'd5);
`else
        chk("ill_fetch",   32'(State),   32'd0);
        chk("ill_flag",    32'(Illegal), 32'd0);
        chk("ill_instret", Instret,      32'd5);
`endif

        // Reset pulse, then reset asserted in the middle of MEMREAD
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        op = 7'b0000011;
        step(); step(); step();
        chk("mr_state", 32'(State), 32'd3);
        MemReady = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("mr_rst_state",   32'(State),   32'd0);
        chk("mr_rst_adrsrc",  32'(AdrSrc),  32'd0);
        chk("mr_rst_illegal", 32'(Illegal), 32'd0);
        chk("mr_rst_instret", Instret,      32'd0);
        step();
        reset_n  = 1'b1;
        MemReady = 1'b1;
        op       = 7'b0110011;

        // 16 R-type instructions: 4-bit counter wraps 15 -> 0
        for (int i = 0; i < 15; i++) repeat (4) step();
        chk("wrap_15",   32'(Instret_4), 32'd15);
        repeat (4) step();
        chk("wrap_0",    32'(Instret_4), 32'd0);
        chk("wrap_w32",  Instret,        32'd16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
